// File: rtl/data_ram_pkg.sv
// Shared definitions for the sweep-cleared data RAM: FSM encoding and lane helper.
package data_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  function automatic int lanes_of(input int d_w, input int lane_w);
    return d_w / lane_w;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Storage only: synchronous read-before-write array with per-lane write enables.
module data_ram_array #(
  parameter int A_W    = 8,
  parameter int D_W    = 8,
  parameter int LANE_W = 8
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [D_W/LANE_W-1:0]   lane_mask_i,
  input  logic [A_W-1:0]          addr_i,
  input  logic [D_W-1:0]          wdata_i,
  output logic [D_W-1:0]          rdata_o
);

  localparam int LANES = D_W / LANE_W;

  logic [D_W-1:0] mem_q [2**A_W];

  // NOTE: the array has no reset so it maps onto plain RAM; clearing is done by the sweep.
  always_ff @(posedge clk) begin
    rdata_o <= mem_q[addr_i];
    for (int k = 0; k < LANES; k++) begin
      if (we_i && lane_mask_i[k]) begin
        mem_q[addr_i][k*LANE_W +: LANE_W] <= wdata_i[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/data_ram_sweep.sv
// Data RAM for the accumulator processor: port access with a fill sweep that
// runs after reset or on request, rejecting port accesses while it runs.
module data_ram_sweep
  import data_ram_pkg::*;
#(
  parameter int             A_W       = 8,
  parameter int             D_W       = 8,
  parameter int             LANE_W    = 8,
  parameter logic [D_W-1:0] FILL      = '0,
  parameter bit             SWEEP_RST = 1'b1
) (
  input  logic                              clk,
  input  logic                              clear,
  input  logic                              enable,
  input  logic                              read_en,
  input  logic                              write_en,
  input  logic [A_W-1:0]                    addr,
  input  logic [D_W-1:0]                    datain,
  input  logic [lanes_of(D_W, LANE_W)-1:0]  lane_en,
  input  logic                              scrub_req,
  output logic [D_W-1:0]                    dataout,
  output logic                              rd_valid,
  output logic                              busy,
  output logic                              acc_err
);

  localparam int     LANES     = lanes_of(D_W, LANE_W);
  localparam state_e RST_STATE = SWEEP_RST ? ST_SWEEP : ST_IDLE;

  state_e           state_q, state_d;
  logic [A_W-1:0]   ptr_q, ptr_d;
  logic [D_W-1:0]   hold_q;
  logic             rd_valid_q, rd_valid_d;
  logic             acc_err_q, acc_err_d;
  logic             sweeping, access;
  logic             arr_we;
  logic [LANES-1:0] arr_mask;
  logic [A_W-1:0]   arr_addr;
  logic [D_W-1:0]   arr_wdata, arr_rdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (scrub_req) state_d = ST_SWEEP;
      ST_SWEEP: if (&ptr_q)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The sweep owns the array port outright; port requests only observe it via acc_err.
  always_comb begin
    sweeping   = (state_q == ST_SWEEP);
    busy       = sweeping;
    access     = enable && (read_en || write_en);
    arr_we     = sweeping || (enable && write_en);
    arr_mask   = sweeping ? {LANES{1'b1}} : lane_en;
    arr_addr   = sweeping ? ptr_q : addr;
    arr_wdata  = sweeping ? FILL : datain;
    rd_valid_d = !sweeping && enable && read_en;
    acc_err_d  = sweeping && access;
    ptr_d      = sweeping ? ptr_q + A_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      acc_err_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      acc_err_q  <= acc_err_d;
      if (rd_valid_q) hold_q <= arr_rdata;
    end
  end

  data_ram_array #(
    .A_W    (A_W),
    .D_W    (D_W),
    .LANE_W (LANE_W)
  ) u_array (
    .clk         (clk),
    .we_i        (arr_we),
    .lane_mask_i (arr_mask),
    .addr_i      (arr_addr),
    .wdata_i     (arr_wdata),
    .rdata_o     (arr_rdata)
  );

  // The array read register follows every cycle; hold_q keeps the last delivered word.
  assign dataout  = rd_valid_q ? arr_rdata : hold_q;
  assign rd_valid = rd_valid_q;
  assign acc_err  = acc_err_q;

endmodule

// File: tb/tb_data_ram_sweep.sv
// Self-checking bench for data_ram_sweep: behavioural model plus read-data scoreboard.
module tb_data_ram_sweep;

  localparam int          A_W  = 4;
  localparam int          D_W  = 16;
  localparam int          LW   = 8;
  localparam logic [15:0] FILL = 16'hA5A5;

  logic        clk = 1'b0;
  logic        clear;
  logic        enable, read_en, write_en, scrub_req;
  logic [3:0]  addr;
  logic [15:0] datain;
  logic [1:0]  lane_en;
  logic [15:0] dataout;
  logic        rd_valid, busy, acc_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mmem [16];
  logic        mbusy;
  logic [3:0]  mptr;
  logic [15:0] mdout;
  logic [15:0] sb_q [$];

  data_ram_sweep #(
    .A_W       (A_W),
    .D_W       (D_W),
    .LANE_W    (LW),
    .FILL      (FILL),
    .SWEEP_RST (1'b1)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .enable    (enable),
    .read_en   (read_en),
    .write_en  (write_en),
    .addr      (addr),
    .datain    (datain),
    .lane_en   (lane_en),
    .scrub_req (scrub_req),
    .dataout   (dataout),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .acc_err   (acc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input logic en, input logic re, input logic we, input logic [3:0] a,
                      input logic [15:0] d, input logic [1:0] le, input logic scrub);
    logic exp_rv, exp_err, busy_n;
    logic [15:0] got;
    enable = en; read_en = re; write_en = we; addr = a; datain = d; lane_en = le;
    scrub_req = scrub;
    exp_rv  = !mbusy && en && re;
    exp_err = mbusy && en && (re || we);
    busy_n  = mbusy;
    if (exp_rv) sb_q.push_back(mmem[a]);
    if (mbusy) begin
      mmem[mptr] = FILL;
      if (mptr == 4'hF) busy_n = 1'b0;
      mptr = mptr + 4'd1;
    end else begin
      if (en && we) begin
        for (int k = 0; k < 2; k++)
          if (le[k]) mmem[a][k*LW +: LW] = d[k*LW +: LW];
      end
      if (scrub) busy_n = 1'b1;
    end
    mbusy = busy_n;
    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, exp_rv);
    check("acc_err", acc_err, exp_err);
    check("busy", busy, mbusy);
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rd_valid", 1, 0);
      end else begin
        got   = sb_q.pop_front();
        mdout = got;
        check("read_data", dataout, got);
      end
    end else begin
      check("dataout_hold", dataout, mdout);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic read_expect(input string tag, input logic [3:0] a, input logic [15:0] exp);
    step(1'b1, 1'b1, 1'b0, a, 16'h0, 2'b00, 1'b0);
    check(tag, dataout, exp);
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] le);
    step(1'b1, 1'b0, 1'b1, a, d, le, 1'b0);
  endtask

  // Idle until the DUT drops busy; the number of edges taken is the sweep length.
  task automatic sweep_count(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      n++;
      if (!busy) break;
    end
  endtask

  task automatic pulse_reset();
    clear = 1'b0;
    mbusy = 1'b1; mptr = 4'd0; mdout = 16'h0;
    sb_q.delete();
    #3;
    check("rst_dataout", dataout, 16'h0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_acc_err", acc_err, 0);
    check("rst_busy", busy, 1);
    clear = 1'b1;
  endtask

  initial begin
    int n;
    enable = 0; read_en = 0; write_en = 0; scrub_req = 0;
    addr = '0; datain = '0; lane_en = '0;
    for (int i = 0; i < 16; i++) mmem[i] = 16'hxxxx;
    clear = 1'b0;
    mbusy = 1'b1; mptr = 4'd0; mdout = 16'h0;
    #9;

    // 1: reset release, full sweep, then every word reads FILL
    pulse_reset();
    sweep_count(n);
    check("sweep_len_reset", n, 16);
    for (int i = 0; i < 16; i++) read_expect("fill_read", 4'(i), 16'hA5A5);

    // 2: lane-masked writes, read on the next cycle
    write(4'd3, 16'h1234, 2'b01);
    read_expect("lane0_write", 4'd3, 16'hA534);
    write(4'd3, 16'hBEEF, 2'b10);
    read_expect("lane1_write", 4'd3, 16'hBE34);
    write(4'd4, 16'hFFFF, 2'b00);
    read_expect("no_lane_write", 4'd4, 16'hA5A5);

    // 3: read+write collision returns old data, write still commits
    step(1'b1, 1'b1, 1'b1, 4'd5, 16'h0F0F, 2'b11, 1'b0);
    check("rmw_old", dataout, 16'hA5A5);
    read_expect("rmw_new", 4'd5, 16'h0F0F);

    // 5: enable low holds dataout
    write(4'd7, 16'h1234, 2'b11);
    read_expect("hold_src", 4'd7, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 4'd3, 16'h0, 2'b00, 1'b0);
    check("en0_dataout", dataout, 16'h1234);
    check("en0_rd_valid", rd_valid, 0);

    // 4: scrub with a rejected write at sweep cycle 4 and an ignored re-request
    write(4'd2, 16'h1111, 2'b11);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) begin
        step(1'b1, 1'b0, 1'b1, 4'd2, 16'h0000, 2'b11, 1'b0);
        check("sweep_acc_err", acc_err, 1);
      end else if (i == 8) begin
        step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1);
      end else begin
        idle();
      end
      n++;
      if (!busy) break;
    end
    check("sweep_len_scrub", n, 16);
    check("acc_err_pulse", acc_err, 0);
    read_expect("scrubbed_addr2", 4'd2, 16'hA5A5);
    read_expect("scrubbed_addr7", 4'd7, 16'hA5A5);

    // 6: reset in the middle of a sweep restarts it from pointer 0
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    pulse_reset();
    sweep_count(n);
    check("sweep_len_abort", n, 16);
    read_expect("post_abort_read", 4'd15, 16'hA5A5);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
